rf_move_ctrl: RTL

- Command-driven sequencer that owns the write port and read port 0 of the 2-read/1-write register file (async read, posedge write).
- Executes block COPY (register-to-register move, overlap-safe) and block FILL (constant store) over a contiguous, wrap-around address range.
- Sits between a host command source and the register file; read port 1 stays with the host datapath.

---
 rtl/rf_move_ctrl_pkg.sv | 19 +
 rtl/rf_move_agu.sv | 58 +++++
 rtl/rf_move_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/rf_move_ctrl_pkg.sv
// Shared encodings and default widths for the register-file move sequencer.
package rf_move_ctrl_pkg;

   localparam int unsigned BW_DATA_DEF = 16;
   localparam int unsigned BW_ADDR_DEF = 4;

   typedef enum logic {
      OP_COPY = 1'b0,
      OP_FILL = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/rf_move_agu.sv
// Address generator: latches bases/length, picks copy direction, steps pointers.
module rf_move_agu
   import rf_move_ctrl_pkg::*;
#(
   parameter int unsigned BW_ADDR = BW_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               advance,
   input  op_e                op,
   input  logic [BW_ADDR-1:0] src,
   input  logic [BW_ADDR-1:0] dst,
   input  logic [BW_ADDR:0]   len,
   output logic [BW_ADDR-1:0] src_ptr,
   output logic [BW_ADDR-1:0] dst_ptr,
   output logic               last_c
);

   localparam int unsigned   DEPTH   = 2 ** BW_ADDR;
   localparam logic [BW_ADDR:0] DEPTH_L = (BW_ADDR + 1)'(DEPTH);

   logic [BW_ADDR:0]   eff_len;
   logic [BW_ADDR-1:0] off;
   logic [BW_ADDR-1:0] span;
   logic               desc;
   logic               desc_q;
   logic [BW_ADDR:0]   rem_q;

   // Descending order only when the destination window starts inside the source window.
   always_comb begin
      eff_len = (len > DEPTH_L) ? DEPTH_L : len;
      off     = dst - src;
      span    = BW_ADDR'(eff_len - (BW_ADDR + 1)'(1));
      desc    = (op == OP_COPY) && (off != '0) && ({1'b0, off} < eff_len);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_ptr <= '0;
         dst_ptr <= '0;
         rem_q   <= '0;
         desc_q  <= 1'b0;
      end else if (load) begin
         src_ptr <= desc ? src + span : src;
         dst_ptr <= desc ? dst + span : dst;
         rem_q   <= eff_len;
         desc_q  <= desc;
      end else if (advance) begin
         src_ptr <= desc_q ? src_ptr - BW_ADDR'(1) : src_ptr + BW_ADDR'(1);
         dst_ptr <= desc_q ? dst_ptr - BW_ADDR'(1) : dst_ptr + BW_ADDR'(1);
         rem_q   <= rem_q - (BW_ADDR + 1)'(1);
      end
   end

   assign last_c = (rem_q == (BW_ADDR + 1)'(1));

endmodule

// File: rtl/rf_move_ctrl.sv
// Block COPY / FILL sequencer owning the register-file write port and read port 0.
module rf_move_ctrl
   import rf_move_ctrl_pkg::*;
#(
   parameter int unsigned BW_DATA = BW_DATA_DEF,
   parameter int unsigned BW_ADDR = BW_ADDR_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic               i_cmd_op,
   input  logic [BW_ADDR-1:0] i_cmd_src,
   input  logic [BW_ADDR-1:0] i_cmd_dst,
   input  logic [BW_ADDR:0]   i_cmd_len,
   input  logic [BW_DATA-1:0] i_cmd_data,
   output logic               o_busy,
   output logic               o_done,
   output logic [BW_ADDR-1:0] o_rf_rd_addr0,
   input  logic [BW_DATA-1:0] i_rf_rd_data0,
   output logic [BW_ADDR-1:0] o_rf_wr_addr,
   output logic [BW_DATA-1:0] o_rf_wr_data,
   output logic               o_rf_wr_en
);

   state_e             state_q, state_d;
   op_e                op_q;
   logic [BW_DATA-1:0] data_q;
   logic [BW_ADDR-1:0] rd_hold_q;
   logic [BW_ADDR-1:0] src_ptr;
   logic [BW_ADDR-1:0] dst_ptr;
   logic               last_c;
   logic               load;
   logic               advance;

   rf_move_agu #(.BW_ADDR(BW_ADDR)) u_agu (
      .clk     (i_clk),
      .rst     (i_rst),
      .load    (load),
      .advance (advance),
      .op      (op_e'(i_cmd_op)),
      .src     (i_cmd_src),
      .dst     (i_cmd_dst),
      .len     (i_cmd_len),
      .src_ptr (src_ptr),
      .dst_ptr (dst_ptr),
      .last_c  (last_c)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               load = 1'b1;
               if (i_cmd_len == '0)                  state_d = S_DONE;
               else if (op_e'(i_cmd_op) == OP_FILL)  state_d = S_WR;
               else                                  state_d = S_RD;
            end
         end
         S_RD: state_d = S_WR;
         S_WR: begin
            advance = 1'b1;
            if (last_c)                state_d = S_DONE;
            else if (op_q == OP_FILL)  state_d = S_WR;
            else                       state_d = S_RD;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Data register holds the fill value, or the element just read for a copy.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         op_q      <= OP_COPY;
         data_q    <= '0;
         rd_hold_q <= '0;
      end else begin
         if (load) begin
            op_q   <= op_e'(i_cmd_op);
            data_q <= i_cmd_data;
         end
         if (state_q == S_RD) begin
            data_q    <= i_rf_rd_data0;
            rd_hold_q <= src_ptr;
         end
      end
   end

   assign o_cmd_ready   = (state_q == S_IDLE);
   assign o_busy        = (state_q == S_RD) || (state_q == S_WR);
   assign o_done        = (state_q == S_DONE);
   assign o_rf_wr_en    = (state_q == S_WR);
   assign o_rf_rd_addr0 = (state_q == S_RD) ? src_ptr : rd_hold_q;
   assign o_rf_wr_addr  = dst_ptr;
   assign o_rf_wr_data  = data_q;

endmodule
